// File: rtl/fc28_seq_pkg.sv
// Shared register map, bit positions and sequencer states for the FC-28 sample sequencer.
`timescale 1ns/1ps
package fc28_seq_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_START = 1;
  localparam int CTRL_IRQEN = 2;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVR  = 2;

  typedef enum logic [1:0] {IDLE, POWER, SAMPLE, DONE} state_t;

endpackage

// File: rtl/fc28_period_timer.sv
// Free-running period counter: reloads when enabled and pulses o_trig every i_period cycles.
`timescale 1ns/1ps
module fc28_period_timer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [31:0] i_period,
  output logic        o_trig
);

  logic        r_en_d;
  logic [31:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en_d <= 1'b0;
      r_cnt  <= '0;
      o_trig <= 1'b0;
    end else begin
      r_en_d <= i_enable;
      if (!i_enable) begin
        o_trig <= 1'b0;
      end else if (!r_en_d) begin
        r_cnt  <= '0;
        o_trig <= 1'b0;
      // >= rather than == so a shrinking PERIOD cannot strand the counter above the limit
      end else if ((i_period == 32'd0) || (r_cnt >= (i_period - 32'd1))) begin
        r_cnt  <= '0;
        o_trig <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 32'd1;
        o_trig <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fc28_sample_sequencer.sv
// Avalon-MM FC-28 measurement sequencer: power probe, settle, sample, majority vote, power down.
`timescale 1ns/1ps
module fc28_sample_sequencer
  import fc28_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 50000,
  parameter int NUM_SAMPLES   = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        sensor_do,
  output logic        sensor_pwr,
  output logic        irq
);

  state_t                 r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [31:0]            r_settle, r_period, w_rdata;
  logic [3:0]             r_samp, r_acc, r_ones;
  logic [7:0]             r_count;
  logic r_enable, r_irq_en, r_done, r_overrun, r_result, r_pending, r_pend_tmr;
  logic w_tmr_raw, w_tmr, w_start, w_trig, w_ctrl_wr, w_per_wr, w_st_wr;
  logic w_busy, w_sample, w_vote, w_pend_n, w_ptmr_n, w_ovr_set, w_done_n, w_ovr_n, w_irq_en_n;

  fc28_period_timer u_timer (
    .i_clk    (clk),
    .i_rst_n  (reset_n),
    .i_enable (r_enable),
    .i_period (r_period),
    .o_trig   (w_tmr_raw)
  );

  assign w_ctrl_wr  = write && (address == REG_CTRL);
  assign w_per_wr   = write && (address == REG_PERIOD);
  assign w_st_wr    = write && (address == REG_STATUS);
  assign w_start    = w_ctrl_wr && writedata[CTRL_START];
  // Gate the registered timer pulse so one issued just before a disable cannot leak through
  assign w_tmr      = w_tmr_raw && r_enable;
  assign w_trig     = w_start || w_tmr;
  assign w_busy     = (r_state != IDLE);
  assign w_sample   = r_sync[SYNC_STAGES-1];
  assign w_vote     = ({1'b0, r_acc} << 1) > 5'(NUM_SAMPLES);
  assign w_irq_en_n = w_ctrl_wr ? writedata[CTRL_IRQEN] : r_irq_en;
  assign w_done_n   = (r_state == DONE) ? 1'b1 : ((w_st_wr && writedata[ST_DONE]) ? 1'b0 : r_done);
  assign w_ovr_n    = w_ovr_set ? 1'b1 : ((w_st_wr && writedata[ST_OVR]) ? 1'b0 : r_overrun);

  // One trigger may wait while busy; the source is kept so a disable can drop timer triggers
  always_comb begin
    w_pend_n  = r_pending;
    w_ptmr_n  = r_pend_tmr;
    w_ovr_set = 1'b0;
    if (r_state == IDLE) begin
      if (r_pending) begin
        w_pend_n = w_trig;
        w_ptmr_n = w_tmr && !w_start;
      end
    end else if (w_trig) begin
      if (!r_pending) begin
        w_pend_n = 1'b1;
        w_ptmr_n = w_tmr && !w_start;
      end else begin
        w_ovr_set = 1'b1;
      end
    end
    if (w_ctrl_wr && !writedata[CTRL_EN] && w_ptmr_n) begin
      w_pend_n = 1'b0;
      w_ptmr_n = 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_trig || r_pending) w_next = POWER;
      POWER:   if (r_settle == 32'(SETTLE_CYCLES - 1)) w_next = SAMPLE;
      SAMPLE:  if (r_samp == 4'(NUM_SAMPLES - 1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      REG_CTRL:   w_rdata = {29'd0, r_irq_en, 1'b0, r_enable};
      REG_PERIOD: w_rdata = r_period;
      REG_STATUS: w_rdata = {24'd0, r_ones, 1'b0, r_overrun, r_done, w_busy};
      REG_RESULT: w_rdata = {16'd0, r_count, 7'd0, r_result};
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync     <= '0;
      r_settle   <= '0;
      r_samp     <= '0;
      r_acc      <= '0;
      r_ones     <= '0;
      r_count    <= '0;
      r_period   <= '0;
      r_enable   <= 1'b0;
      r_irq_en   <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_result   <= 1'b0;
      r_pending  <= 1'b0;
      r_pend_tmr <= 1'b0;
      readdata   <= '0;
      sensor_pwr <= 1'b0;
      irq        <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], sensor_do};
      r_settle   <= (r_state == POWER) ? r_settle + 32'd1 : 32'd0;
      r_samp     <= (r_state == SAMPLE) ? r_samp + 4'd1 : 4'd0;
      if (r_state == POWER)  r_acc <= '0;
      if (r_state == SAMPLE) r_acc <= r_acc + {3'd0, w_sample};
      if (r_state == DONE) begin
        r_result <= w_vote;
        r_ones   <= r_acc;
        r_count  <= r_count + 8'd1;
      end
      if (w_ctrl_wr) r_enable <= writedata[CTRL_EN];
      if (w_per_wr)  r_period <= writedata;
      r_irq_en   <= w_irq_en_n;
      r_done     <= w_done_n;
      r_overrun  <= w_ovr_n;
      r_pending  <= w_pend_n;
      r_pend_tmr <= w_ptmr_n;
      readdata   <= w_rdata;
      sensor_pwr <= (w_next != IDLE);
      irq        <= w_done_n && w_irq_en_n;
    end
  end

endmodule
